// File: rtl/status_cond_unit_pkg.sv
// Shared ARM status definitions: flag bit positions and condition-code encodings,
// common to the condition decoder and the ALU flag path.
package status_cond_unit_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'ha, COND_LT = 4'hb,
    COND_GT = 4'hc, COND_LE = 4'hd, COND_AL = 4'he, COND_NV = 4'hf
  } cond_e;

  function automatic logic [3:0] flags_pack(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/status_cond_unit_if.sv
// Pipeline-side signals of the status/condition unit: EX flag writeback, ID condition query.
interface status_cond_unit_if;
  logic       ex_valid;
  logic       ex_s;
  logic       alu_n;
  logic       alu_z;
  logic       alu_c;
  logic       alu_v;
  logic       id_valid;
  logic [3:0] id_cond;
  logic [3:0] flags;
  logic       cin;
  logic       cond_true;
  logic       cond_true_q;
  logic       fwd_hit;

  modport master (
    output ex_valid, ex_s, alu_n, alu_z, alu_c, alu_v, id_valid, id_cond,
    input  flags, cin, cond_true, cond_true_q, fwd_hit
  );

  modport slave (
    input  ex_valid, ex_s, alu_n, alu_z, alu_c, alu_v, id_valid, id_cond,
    output flags, cin, cond_true, cond_true_q, fwd_hit
  );
endinterface

// File: rtl/status_cond_unit_cond_eval.sv
// Combinational ARM condition-code evaluator over a {N,Z,C,V} flag vector.
module cond_eval
  import status_cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_cond_unit.sv
// Status flag register with optional EX->ID flag forwarding and ID-stage condition check.
module status_cond_unit
  import status_cond_unit_pkg::*;
#(
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  status_cond_unit_if.slave bus
);

  localparam bit FWD = (FWD_EN != 0);

  logic       we;
  logic [3:0] alu_flags;
  logic [3:0] flags_q;
  logic [3:0] ef;
  logic       pass;
  logic       cond_true;
  logic       cond_true_q;

  assign we        = bus.ex_valid & bus.ex_s;
  assign alu_flags = flags_pack(bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v);

  // Without forwarding the ID check sees pre-update flags; the pipeline must stall.
  assign ef = (FWD && we) ? alu_flags : flags_q;

  cond_eval u_cond_eval (
    .cond  (bus.id_cond),
    .flags (ef),
    .pass  (pass)
  );

  assign cond_true = bus.id_valid & pass;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q     <= '0;
      cond_true_q <= 1'b0;
    end else begin
      if (we) flags_q <= alu_flags;
      cond_true_q <= cond_true;
    end
  end

  assign bus.flags       = flags_q;
  assign bus.cin         = flags_q[FLAG_C];
  assign bus.cond_true   = cond_true;
  assign bus.cond_true_q = cond_true_q;
  assign bus.fwd_hit     = FWD & we & bus.id_valid;

endmodule

// File: tb/tb_status_cond_unit.sv
// Bench for status_cond_unit: forwarding and non-forwarding instances driven in lockstep
// against a behavioural flag/condition model.
module tb_status_cond_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       ex_valid, ex_s, id_valid;
  logic [3:0] alu;      // {N,Z,C,V}
  logic [3:0] id_cond;

  int tests = 0;
  int fails = 0;

  logic [3:0] mflags;
  logic       mctq1, mctq0;

  always #5 clk = ~clk;

  status_cond_unit_if bus1 ();
  status_cond_unit_if bus0 ();

  assign bus1.ex_valid = ex_valid;  assign bus0.ex_valid = ex_valid;
  assign bus1.ex_s     = ex_s;      assign bus0.ex_s     = ex_s;
  assign bus1.alu_n    = alu[3];    assign bus0.alu_n    = alu[3];
  assign bus1.alu_z    = alu[2];    assign bus0.alu_z    = alu[2];
  assign bus1.alu_c    = alu[1];    assign bus0.alu_c    = alu[1];
  assign bus1.alu_v    = alu[0];    assign bus0.alu_v    = alu[0];
  assign bus1.id_valid = id_valid;  assign bus0.id_valid = id_valid;
  assign bus1.id_cond  = id_cond;   assign bus0.id_cond  = id_cond;

  status_cond_unit #(.FWD_EN(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  status_cond_unit #(.FWD_EN(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Condition pairs: even code is the predicate, odd code its inverse; AL/NV is the 1/0 pair.
  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, p;
    int   grp;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    grp = int'(cc) / 2;
    case (grp)
      0:       p = z;
      1:       p = c;
      2:       p = n;
      3:       p = v;
      4:       p = c && !z;
      5:       p = (n == v);
      6:       p = !z && (n == v);
      default: p = 1'b1;
    endcase
    if (cc % 2 == 1) p = !p;
    return p;
  endfunction

  function automatic logic exp_ct(input bit fwd);
    logic [3:0] f;
    f = (fwd && ex_valid && ex_s) ? alu : mflags;
    return id_valid && ref_cond(id_cond, f);
  endfunction

  function automatic logic exp_hit(input bit fwd);
    return fwd && ex_valid && ex_s && id_valid;
  endfunction

  task automatic step();
    logic c1, c0;
    @(posedge clk);
    c1 = exp_ct(1'b1);
    c0 = exp_ct(1'b0);
    if (reset) begin
      mflags = 4'b0000; mctq1 = 1'b0; mctq0 = 1'b0;
    end else begin
      mctq1 = c1; mctq0 = c0;
      if (ex_valid && ex_s) mflags = alu;
    end
    #2;
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, ".flags1"}, 32'(bus1.flags),       32'(mflags));
    chk({tag, ".flags0"}, 32'(bus0.flags),       32'(mflags));
    chk({tag, ".cin1"},   32'(bus1.cin),         32'(mflags[1]));
    chk({tag, ".cin0"},   32'(bus0.cin),         32'(mflags[1]));
    chk({tag, ".ct1"},    32'(bus1.cond_true),   32'(exp_ct(1'b1)));
    chk({tag, ".ct0"},    32'(bus0.cond_true),   32'(exp_ct(1'b0)));
    chk({tag, ".hit1"},   32'(bus1.fwd_hit),     32'(exp_hit(1'b1)));
    chk({tag, ".hit0"},   32'(bus0.fwd_hit),     32'(exp_hit(1'b0)));
    chk({tag, ".ctq1"},   32'(bus1.cond_true_q), 32'(mctq1));
    chk({tag, ".ctq0"},   32'(bus0.cond_true_q), 32'(mctq0));
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_s = 1'b0; alu = 4'b0000; id_valid = 1'b0; id_cond = 4'h0;
  endtask

  initial begin
    logic [31:0] a;
    logic [32:0] r;
    mflags = 4'b0000; mctq1 = 1'b0; mctq0 = 1'b0;
    idle();
    reset = 1'b1;
    #2;

    // Reset state and first queries
    step();
    reset = 1'b0;
    chk("rst.flags", 32'(bus1.flags), 32'h0);
    chk("rst.cin",   32'(bus1.cin),   32'h0);
    chk("rst.ctq",   32'(bus1.cond_true_q), 32'h0);
    id_valid = 1'b1; id_cond = 4'b0000;
    #1 chk("rst.eq", 32'(bus1.cond_true), 32'h0);
    id_cond = 4'b0001;
    #1 chk("rst.ne", 32'(bus1.cond_true), 32'h1);
    check_all("rst");

    // ADD 0x9C000038 + 0x9C000038 flag capture
    a = 32'h9C000038;
    r = {1'b0, a} + {1'b0, a};
    ex_valid = 1'b1; ex_s = 1'b1; id_valid = 1'b0;
    alu = {r[31], (r[31:0] == 32'h0), r[32], (a[31] == a[31]) && (r[31] != a[31])};
    step();
    ex_valid = 1'b0; ex_s = 1'b0;
    chk("add.flags", 32'(bus1.flags), 32'h3);
    chk("add.cin",   32'(bus1.cin),   32'h1);
    id_valid = 1'b1; id_cond = 4'b0110;
    #1 chk("add.vs", 32'(bus1.cond_true), 32'h1);
    check_all("add");

    // Forwarding of SUB 0x9C000038 - 0x9C000038 against cleared flags
    reset = 1'b1; idle();
    step();
    reset = 1'b0;
    r = {1'b0, a} + {1'b0, ~a} + 33'd1;
    alu = {r[31], (r[31:0] == 32'h0), r[32], (a[31] != a[31]) && (r[31] != a[31])};
    ex_valid = 1'b1; ex_s = 1'b1; id_valid = 1'b1; id_cond = 4'b0000;
    #1;
    chk("fwd.ct1",  32'(bus1.cond_true), 32'h1);
    chk("fwd.hit1", 32'(bus1.fwd_hit),   32'h1);
    chk("fwd.ct0",  32'(bus0.cond_true), 32'h0);
    chk("fwd.hit0", 32'(bus0.fwd_hit),   32'h0);
    check_all("fwd");
    step();

    // Write-enable hold cases
    alu = 4'b0100; ex_valid = 1'b1; ex_s = 1'b1;
    step();
    alu = 4'b1111; ex_s = 1'b0;
    step();
    chk("hold.s0", 32'(bus1.flags), 32'h4);
    ex_s = 1'b1; ex_valid = 1'b0;
    step();
    chk("hold.v0", 32'(bus1.flags), 32'h4);
    check_all("hold");

    // Reset dominates a same-edge write
    reset = 1'b1; ex_valid = 1'b1; ex_s = 1'b1; alu = 4'b1111;
    step();
    chk("rw.rst", 32'(bus1.flags), 32'h0);
    reset = 1'b0; alu = 4'b1010;
    step();
    chk("rw.wr", 32'(bus1.flags), 32'ha);
    check_all("rw");

    // Every condition code against every stored flag value
    for (int f = 0; f < 16; f++) begin
      ex_valid = 1'b1; ex_s = 1'b1; alu = 4'(f); id_valid = 1'b0;
      step();
      ex_valid = 1'b0; ex_s = 1'b0; alu = 4'(~f); id_valid = 1'b1;
      for (int c = 0; c < 16; c++) begin
        id_cond = 4'(c);
        #1;
        chk("exh.ct1", 32'(bus1.cond_true), 32'(ref_cond(4'(c), 4'(f))));
        chk("exh.ct0", 32'(bus0.cond_true), 32'(ref_cond(4'(c), 4'(f))));
      end
      id_cond = 4'he; id_valid = 1'b0;
      #1 chk("exh.inv", 32'(bus1.cond_true), 32'h0);
      step();
      chk("exh.invq", 32'(bus1.cond_true_q), 32'h0);
    end

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 15) == 0);
      ex_valid = 1'($urandom);
      ex_s     = 1'($urandom);
      alu      = 4'($urandom);
      id_valid = ($urandom_range(0, 3) != 0);
      id_cond  = 4'($urandom);
      check_all("rnd");
      step();
    end
    reset = 1'b0; idle();
    check_all("end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
